// File: rtl/lcd_8080_engine.sv
// 8080-style parallel LCD bus engine: command writes/reads and FIFO-fed pixel frames.
// Ports: clk/rst_n, i_enable, i_cmd_* / o_cmd_* (register access), i_frame_start,
//   i_num_pixels, o_frame_done (frame control), i_pix_* / o_pix_ready / o_fifo_count
//   (pixel push side), o_busy, o_register_data_sel, o_write_n, o_read_n, io_data (panel).
module lcd_8080_engine #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PIXEL_WIDTH     = 16,
  parameter int unsigned WR_LOW_CYCLES   = 2,
  parameter int unsigned WR_HIGH_CYCLES  = 2,
  parameter int unsigned RD_LOW_CYCLES   = 3,
  parameter int unsigned RD_HIGH_CYCLES  = 2,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter logic [7:0]  MEM_WRITE_CMD   = 8'h2C
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic                       i_cmd_parameter,
  input  logic                       i_cmd_write_stb,
  input  logic                       i_cmd_read_stb,
  input  logic [DATA_WIDTH-1:0]      i_cmd_data,
  output logic [DATA_WIDTH-1:0]      o_cmd_data,
  output logic                       o_cmd_finished,
  output logic                       o_busy,
  input  logic                       i_frame_start,
  input  logic [31:0]                i_num_pixels,
  output logic                       o_frame_done,
  input  logic                       i_pix_valid,
  output logic                       o_pix_ready,
  input  logic [PIXEL_WIDTH-1:0]     i_pix_data,
  output logic [FIFO_ADDR_WIDTH:0]   o_fifo_count,
  output logic                       o_register_data_sel,
  output logic                       o_write_n,
  output logic                       o_read_n,
  inout  wire  [DATA_WIDTH-1:0]      io_data
);

  localparam int unsigned BEATS = PIXEL_WIDTH / DATA_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CW    = 16;

  localparam logic [CW-1:0] WRL = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] WRH = CW'(WR_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] RDL = CW'(RD_LOW_CYCLES - 1);
  localparam logic [CW-1:0] RDH = CW'(RD_HIGH_CYCLES - 1);
  localparam logic [BW-1:0] LASTB = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LOW, S_WR_HIGH, S_RD_LOW, S_RD_HIGH
  } state_e;

  typedef enum logic [1:0] {
    C_CMD, C_FRAME_CMD, C_PIXEL
  } ctx_e;

  state_e                  state_q, state_d;
  ctx_e                    ctx_q, ctx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    rs_q, rs_d;
  logic [PIXEL_WIDTH-1:0]  pix_q, pix_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [31:0]             left_q, left_d;
  logic                    frame_q, frame_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    fin_q, fin_d;
  logic                    done_q, done_d;

  logic [PIXEL_WIDTH-1:0]     mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_q, rd_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q;
  logic                       push, pop, flush, empty, full;
  logic                       start_pix, drive;
  logic [PIXEL_WIDTH-1:0]     fifo_out;

  // Count MSB is set only at exactly DEPTH entries.
  assign full        = count_q[FIFO_ADDR_WIDTH];
  assign empty       = (count_q == '0);
  assign o_pix_ready = !full && i_enable;
  assign push        = i_pix_valid && o_pix_ready;
  assign fifo_out    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= i_pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctx_q   <= C_CMD;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b1;
      pix_q   <= '0;
      beat_q  <= '0;
      left_q  <= '0;
      frame_q <= 1'b0;
      rdata_q <= '0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      pix_q   <= pix_d;
      beat_q  <= beat_d;
      left_q  <= left_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rs_d      = rs_q;
    pix_d     = pix_q;
    beat_d    = beat_q;
    left_d    = left_q;
    frame_d   = frame_q;
    rdata_d   = rdata_q;
    fin_d     = 1'b0;
    done_d    = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    start_pix = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_q) begin
          // Mid-frame wait for pixels; disabling here aborts the frame.
          if (!i_enable) begin
            frame_d = 1'b0;
            flush   = 1'b1;
          end else if (!empty) begin
            start_pix = 1'b1;
          end
        end else if (i_enable) begin
          if (i_cmd_write_stb) begin
            ctx_d   = C_CMD;
            rs_d    = i_cmd_parameter;
            data_d  = i_cmd_data;
            cnt_d   = WRL;
            state_d = S_WR_LOW;
          end else if (i_cmd_read_stb) begin
            ctx_d   = C_CMD;
            rs_d    = 1'b1;
            cnt_d   = RDL;
            state_d = S_RD_LOW;
          end else if (i_frame_start && (i_num_pixels != '0)) begin
            ctx_d   = C_FRAME_CMD;
            rs_d    = 1'b0;
            data_d  = DATA_WIDTH'(MEM_WRITE_CMD);
            left_d  = i_num_pixels;
            frame_d = 1'b1;
            cnt_d   = WRL;
            state_d = S_WR_LOW;
          end
        end
      end
      S_WR_LOW: begin
        if (cnt_q == '0) begin
          cnt_d   = WRH;
          state_d = S_WR_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          if (!i_enable) begin
            flush   = frame_q;
            frame_d = 1'b0;
          end else if (ctx_q == C_CMD) begin
            fin_d = 1'b1;
          end else if (ctx_q == C_PIXEL && beat_q != '0) begin
            data_d  = pix_q[PIXEL_WIDTH-1 -: DATA_WIDTH];
            pix_d   = pix_q << DATA_WIDTH;
            beat_d  = beat_q - 1'b1;
            cnt_d   = WRL;
            state_d = S_WR_LOW;
          end else if (left_q == '0) begin
            done_d  = 1'b1;
            frame_d = 1'b0;
          end else if (!empty) begin
            start_pix = 1'b1;
          end
        end
      end
      S_RD_LOW: begin
        if (cnt_q == '0) begin
          rdata_d = io_data;
          cnt_d   = RDH;
          state_d = S_RD_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_HIGH: begin
        if (cnt_q == '0) begin
          fin_d   = i_enable;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Pop a pixel and send its most significant slice first.
    if (start_pix) begin
      pop     = 1'b1;
      left_d  = left_q - 32'd1;
      ctx_d   = C_PIXEL;
      rs_d    = 1'b1;
      data_d  = fifo_out[PIXEL_WIDTH-1 -: DATA_WIDTH];
      pix_d   = fifo_out << DATA_WIDTH;
      beat_d  = LASTB;
      cnt_d   = WRL;
      state_d = S_WR_LOW;
    end
  end

  always_comb begin
    o_write_n = 1'b1;
    o_read_n  = 1'b1;
    drive     = 1'b0;
    unique case (state_q)
      S_WR_LOW: begin
        o_write_n = 1'b0;
        drive     = 1'b1;
      end
      S_WR_HIGH: drive    = 1'b1;
      S_RD_LOW:  o_read_n = 1'b0;
      default: ;
    endcase
  end

  assign io_data             = drive ? data_q : {DATA_WIDTH{1'bz}};
  assign o_busy              = (state_q != S_IDLE) || frame_q;
  assign o_register_data_sel = rs_q;
  assign o_cmd_data          = rdata_q;
  assign o_cmd_finished      = fin_q;
  assign o_frame_done        = done_q;
  assign o_fifo_count        = count_q;

endmodule

// File: tb/tb_lcd_8080_engine.sv
// Self-checking bench for lcd_8080_engine.
// Random commands and frames checked against a beat-list model of the bus.
module tb_lcd_8080_engine;

  localparam int DW    = 8;
  localparam int PW    = 16;
  localparam int BEATS = PW / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b1;
  logic          i_cmd_parameter = 1'b0;
  logic          i_cmd_write_stb = 1'b0;
  logic          i_cmd_read_stb = 1'b0;
  logic [DW-1:0] i_cmd_data = '0;
  logic [DW-1:0] o_cmd_data;
  logic          o_cmd_finished;
  logic          o_busy;
  logic          i_frame_start = 1'b0;
  logic [31:0]   i_num_pixels = '0;
  logic          o_frame_done;
  logic          i_pix_valid = 1'b0;
  logic          o_pix_ready;
  logic [PW-1:0] i_pix_data = '0;
  logic [4:0]    o_fifo_count;
  logic          o_register_data_sel;
  logic          o_write_n;
  logic          o_read_n;
  wire  [DW-1:0] io_data;
  logic [DW-1:0] rd_val = 8'hA5;

  assign io_data = !o_read_n ? rd_val : {DW{1'bz}};

  always #5 clk = ~clk;

  lcd_8080_engine dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_enable            (i_enable),
    .i_cmd_parameter     (i_cmd_parameter),
    .i_cmd_write_stb     (i_cmd_write_stb),
    .i_cmd_read_stb      (i_cmd_read_stb),
    .i_cmd_data          (i_cmd_data),
    .o_cmd_data          (o_cmd_data),
    .o_cmd_finished      (o_cmd_finished),
    .o_busy              (o_busy),
    .i_frame_start       (i_frame_start),
    .i_num_pixels        (i_num_pixels),
    .o_frame_done        (o_frame_done),
    .i_pix_valid         (i_pix_valid),
    .o_pix_ready         (o_pix_ready),
    .i_pix_data          (i_pix_data),
    .o_fifo_count        (o_fifo_count),
    .o_register_data_sel (o_register_data_sel),
    .o_write_n           (o_write_n),
    .o_read_n            (o_read_n),
    .io_data             (io_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: one record {unstable, rs, data} per write beat.
  logic [9:0]    obs_q[$];
  int            wlen_q[$];
  int            rlen_q[$];
  logic [8:0]    exp_q[$];
  logic [PW-1:0] pend[$];
  int beat_starts = 0;
  int fin_cnt = 0;
  int done_cnt = 0;
  int hl_last = 0;
  logic prev_wn = 1'b1;
  logic prev_rn = 1'b1;
  logic in_high = 1'b0;
  logic unst = 1'b0;
  logic [8:0] cur = '0;
  int wl = 0;
  int rl = 0;
  int hl = 0;

  always @(negedge clk) begin
    if (o_cmd_finished) fin_cnt++;
    if (o_frame_done) done_cnt++;
    if (!o_write_n) begin
      if (prev_wn) begin
        cur = {o_register_data_sel, io_data};
        wl = 1;
        unst = 1'b0;
        beat_starts++;
      end else begin
        wl++;
        if ({o_register_data_sel, io_data} != cur) unst = 1'b1;
      end
      in_high = 1'b0;
    end else begin
      if (!prev_wn) begin
        obs_q.push_back({unst, cur});
        wlen_q.push_back(wl);
        in_high = 1'b1;
        hl = 0;
      end
      if (in_high) begin
        if (o_busy) hl++;
        else begin
          in_high = 1'b0;
          hl_last = hl;
        end
      end
    end
    if (!o_read_n) begin
      if (prev_rn) rl = 1;
      else rl++;
    end else if (!prev_rn) begin
      rlen_q.push_back(rl);
    end
    prev_wn = o_write_n;
    prev_rn = o_read_n;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_pixel(input logic [PW-1:0] p);
    logic [PW-1:0] s;
    for (int b = 0; b < BEATS; b++) begin
      s = p >> (PW - DW * (b + 1));
      exp_q.push_back({1'b1, s[DW-1:0]});
    end
  endtask

  task automatic check_bus(input string tag);
    chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_beat"}, obs_q[i][8:0], exp_q[i]);
      chk({tag, "_stable"}, obs_q[i][9], 1'b0);
      chk({tag, "_wlow"}, wlen_q[i], 2);
    end
    obs_q.delete();
    exp_q.delete();
    wlen_q.delete();
  endtask

  task automatic push_pix(input logic [PW-1:0] p);
    int t = 0;
    i_pix_valid = 1'b1;
    i_pix_data = p;
    while (!o_pix_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    i_pix_valid = 1'b0;
    if (t >= 300) chk("push_timeout", t, 0);
  endtask

  task automatic push_pend();
    foreach (pend[i]) begin
      push_pix(pend[i]);
      exp_pixel(pend[i]);
    end
    pend.delete();
  endtask

  task automatic start_frame(input int n);
    i_num_pixels = 32'(n);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int t = 0;
    int d0 = done_cnt;
    while (!o_frame_done && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, o_frame_done, 1'b1);
    cyc(2);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_fifo"}, o_fifo_count, 0);
  endtask

  task automatic cmd_write(input logic rs, input logic [DW-1:0] d,
                           input logic also_read);
    int lat = 0;
    i_cmd_parameter = rs;
    i_cmd_data = d;
    i_cmd_write_stb = 1'b1;
    i_cmd_read_stb = also_read;
    @(negedge clk);
    i_cmd_write_stb = 1'b0;
    i_cmd_read_stb = 1'b0;
    exp_q.push_back({rs, d});
    while (!o_cmd_finished && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_latency", lat, 4);
    @(negedge clk);
    chk("wr_fin_pulse", o_cmd_finished, 1'b0);
    chk("wr_high", hl_last, 2);
    chk("wr_no_read", rlen_q.size(), 0);
    check_bus("wr");
  endtask

  task automatic cmd_read(input logic [DW-1:0] v);
    int lat = 0;
    rd_val = v;
    i_cmd_read_stb = 1'b1;
    @(negedge clk);
    i_cmd_read_stb = 1'b0;
    while (!o_cmd_finished && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", lat, 5);
    chk("rd_data", o_cmd_data, v);
    chk("rd_low", (rlen_q.size() == 1) ? rlen_q[0] : -1, 3);
    chk("rd_rs", o_register_data_sel, 1'b1);
    rlen_q.delete();
    @(negedge clk);
    chk("rd_fin_pulse", o_cmd_finished, 1'b0);
    check_bus("rd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, b0, d0, f0, t;
    logic [PW-1:0] p;

    rst_n = 1'b0;
    cyc(3);
    chk("rst_write_n", o_write_n, 1'b1);
    chk("rst_read_n", o_read_n, 1'b1);
    chk("rst_rs", o_register_data_sel, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cmd_data", o_cmd_data, 0);
    chk("rst_fin", o_cmd_finished, 1'b0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_fifo", o_fifo_count, 0);
    rst_n = 1'b1;
    cyc(2);

    // Directed command write and read.
    cmd_write(1'b0, 8'h11, 1'b0);
    cmd_read(8'hA5);

    // Random command traffic.
    for (int i = 0; i < 6; i++) begin
      cmd_write(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      if (i % 2 == 0) cmd_read(8'($urandom));
    end

    // Directed three-pixel frame.
    exp_q.push_back({1'b0, 8'h2C});
    pend.push_back(16'h1234);
    pend.push_back(16'hABCD);
    pend.push_back(16'hF00F);
    push_pend();
    chk("f3_count", o_fifo_count, 3);
    start_frame(3);
    wait_done("f3", 200);
    check_bus("f3");

    // Random frames.
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 8);
      exp_q.push_back({1'b0, 8'h2C});
      for (int i = 0; i < n; i++) pend.push_back(PW'($urandom));
      push_pend();
      chk("rf_count", o_fifo_count, n);
      start_frame(n);
      wait_done("rf", 400);
      check_bus("rf");
    end

    // Zero-length frame is ignored.
    b0 = beat_starts;
    d0 = done_cnt;
    start_frame(0);
    cyc(10);
    chk("f0_busy", o_busy, 1'b0);
    chk("f0_beats", beat_starts - b0, 0);
    chk("f0_done", done_cnt - d0, 0);

    // 20-pixel frame with the pusher paused after 16.
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < 16; i++) pend.push_back(PW'($urandom));
    push_pend();
    chk("f20_full_count", o_fifo_count, 16);
    chk("f20_ready_low", o_pix_ready, 1'b0);
    b0 = beat_starts;
    d0 = done_cnt;
    start_frame(20);
    t = 0;
    while (o_fifo_count != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    cyc(12);
    chk("f20_stall_wn", o_write_n, 1'b1);
    chk("f20_stall_busy", o_busy, 1'b1);
    chk("f20_stall_beats", beat_starts - b0, 1 + 16 * BEATS);
    chk("f20_stall_done", done_cnt - d0, 0);
    for (int i = 0; i < 4; i++) pend.push_back(PW'($urandom));
    push_pend();
    wait_done("f20", 200);
    check_bus("f20");

    // Simultaneous write and read strobes: write only.
    cmd_write(1'b1, 8'h3C, 1'b1);

    // Command strobes during a frame are dropped.
    f0 = fin_cnt;
    exp_q.push_back({1'b0, 8'h2C});
    pend.push_back(16'h5AA5);
    pend.push_back(16'h0FF0);
    push_pend();
    start_frame(2);
    cyc(3);
    i_cmd_data = 8'h77;
    i_cmd_write_stb = 1'b1;
    @(negedge clk);
    i_cmd_write_stb = 1'b0;
    i_cmd_read_stb = 1'b1;
    @(negedge clk);
    i_cmd_read_stb = 1'b0;
    wait_done("fstb", 200);
    check_bus("fstb");
    chk("fstb_fin", fin_cnt - f0, 0);
    chk("fstb_no_read", rlen_q.size(), 0);

    // Disable during pixel 2 of 5: that beat finishes, frame aborts.
    for (int i = 0; i < 5; i++) begin
      p = PW'($urandom);
      push_pix(p);
      if (i < 2) exp_pixel(p);
    end
    void'(exp_q.pop_back());
    exp_q.push_front({1'b0, 8'h2C});
    b0 = beat_starts;
    d0 = done_cnt;
    f0 = fin_cnt;
    start_frame(5);
    t = 0;
    while (beat_starts - b0 < 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    i_enable = 1'b0;
    t = 0;
    while (o_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    cyc(2);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_fifo", o_fifo_count, 0);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_fin", fin_cnt - f0, 0);
    check_bus("abort");
    i_enable = 1'b1;
    cyc(2);

    // Asynchronous reset in the middle of WR_LOW.
    push_pix(16'hBEEF);
    i_cmd_parameter = 1'b0;
    i_cmd_data = 8'h5A;
    i_cmd_write_stb = 1'b1;
    @(negedge clk);
    i_cmd_write_stb = 1'b0;
    chk("arst_pre_wn", o_write_n, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wn", o_write_n, 1'b1);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_rs", o_register_data_sel, 1'b1);
    chk("arst_fifo", o_fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    obs_q.delete();
    wlen_q.delete();
    cmd_write(1'b1, 8'hC3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
